// File: rtl/stage_pipe_pkg.sv
// stage_pipe_pkg: shared constants, types and helpers
// for the stage_pipe valid/ready slot chain.
package stage_pipe_pkg;

    localparam int MAX_STAGES = 8;
    localparam int COUNT_W    = 16;

    typedef logic [COUNT_W-1:0] count_t;

    function automatic int occ_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/stage_pipe_if.sv
// stage_pipe_if: upstream and downstream valid/ready bundle
// of stage_pipe; slave is the pipe side, master the user side.
interface stage_pipe_if #(
    parameter int DATA_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/stage_pipe_slot.sv
// stage_pipe_slot: one valid/data register of the chain;
// accepts a beat whenever it is empty or being drained.
module stage_pipe_slot
    import stage_pipe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    input  logic              i_ready_next,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    assign o_ready = !r_valid || i_ready_next;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Valid bit: flush empties the slot, otherwise it follows
    // the upstream valid whenever the slot can take a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
        end
    end

    // Payload: only loads on an accepted beat, so it holds
    // steady while the slot is stalled; no reset needed.
    always_ff @(posedge clk) begin
        if (o_ready && i_valid) begin
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/stage_pipe.sv
// stage_pipe: STAGES-deep valid/ready register chain.
// Define STAGE_PIPE_CNT_EN to add the xfer_count port.
module stage_pipe
    import stage_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    stage_pipe_if.slave                bus,
    output logic [occ_w(STAGES)-1:0]   occupancy
`ifdef STAGE_PIPE_CNT_EN
    ,
    output logic [COUNT_W-1:0]         xfer_count
`endif
);

    localparam int OCC_W = occ_w(STAGES);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("stage_pipe: STAGES must be 1..MAX_STAGES");
    end
    if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
        $error("stage_pipe: DATA_W must be 1..64");
    end

    logic [STAGES:0]   w_valid;
    logic [STAGES:0]   w_ready;
    logic [DATA_W-1:0] w_data [STAGES+1];
    logic              w_in_fire;
    logic              w_out_fire;
    logic [OCC_W-1:0]  r_occ;

    assign w_valid[0]      = bus.in_valid;
    assign w_data[0]       = bus.in_data;
    assign w_ready[STAGES] = bus.out_ready;

    assign bus.in_ready  = w_ready[0] && !flush && rst_n;
    assign bus.out_valid = w_valid[STAGES];
    assign bus.out_data  = w_data[STAGES];

    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_out_fire = w_valid[STAGES] && bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        stage_pipe_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush),
            .i_valid      (w_valid[k]),
            .i_data       (w_data[k]),
            .o_ready      (w_ready[k]),
            .i_ready_next (w_ready[k+1]),
            .o_valid      (w_valid[k+1]),
            .o_data       (w_data[k+1])
        );
    end

    // Occupancy: only the ends of the chain change the beat
    // count; internal slot-to-slot moves leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_fire && !w_out_fire) begin
            r_occ <= r_occ + 1'b1;
        end else if (!w_in_fire && w_out_fire) begin
            r_occ <= r_occ - 1'b1;
        end
    end

    assign occupancy = r_occ;

`ifdef STAGE_PIPE_CNT_EN
    count_t r_xfer;

    // Output transfer counter; a drain during flush still
    // completed, so flush does not touch it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer <= '0;
        end else if (w_out_fire) begin
            r_xfer <= r_xfer + 1'b1;
        end
    end

    assign xfer_count = r_xfer;
`endif

endmodule

// File: doc/stage_pipe.md
STAGE_PIPE -- requirements
Module: stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal 1..64).
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline slots in the chain (legal 1..8).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit, synchronous discard of all held data.
REQ-006 SHALL have port in_valid, input, 1 bit, upstream data valid.
REQ-007 SHALL have port in_ready, output, 1 bit, block can accept in_data.
REQ-008 SHALL have port in_data, input, DATA_W bits, upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit, out_data valid.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accepts.
REQ-011 SHALL have port out_data, output, DATA_W bits, payload from the last slot.
REQ-012 SHALL have port occupancy, output, $clog2(STAGES+1) bits, count of valid slots.
REQ-013 SHALL have port xfer_count, output, 16 bits, count of output transfers; present only under STAGE_PIPE_CNT_EN.

Function
REQ-014 SHALL transfer a beat on any edge where valid and ready are both high on that side.
REQ-015 SHALL hold slot k data stable while slot k valid is high and slot k is not drained.
REQ-016 SHALL set slot k ready = !valid[k] || ready[k+1], with ready[STAGES] = out_ready and in_ready = ready[0] && !flush.
REQ-017 SHALL give a latency of exactly STAGES cycles from an input handshake to out_valid when every slot downstream is empty.
REQ-018 SHALL sustain one beat per cycle with out_ready held high.
REQ-019 SHALL preserve beat order and pass payload unmodified.
REQ-020 SHALL drive out_valid/out_data directly from the last slot register, with no combinational path from in_* to out_*.
REQ-021 SHALL drive occupancy from registers, equal to the number of set slot valid bits after each edge.
REQ-022 SHALL, on a flush cycle, clear every slot valid bit at the next edge, drop any input offered that cycle, and never assert out_valid the cycle after flush.
REQ-023 SHALL count an out_valid && out_ready on the same cycle as flush as a completed transfer.
REQ-024 SHALL, on a simultaneous drain and fill of a full chain, remain full with no bubble inserted.

Reset
REQ-025 SHALL clear all slot valid bits, out_valid, occupancy and xfer_count to 0 asynchronously on rst_n low.
REQ-026 SHALL hold in_ready at 0 while rst_n is low, and at 1 in the first cycle after release.
REQ-027 SHALL discard any in-flight beats on reset mid-operation; slot data registers need no reset.

Configuration
REQ-028 SHALL, with STAGE_PIPE_CNT_EN defined, include xfer_count incrementing by 1 per output handshake and wrapping 0xFFFF->0x0000, unaffected by flush.
REQ-029 SHALL, without STAGE_PIPE_CNT_EN, omit the xfer_count port and counter logic entirely, with all other behaviour identical.

Structure
REQ-030 SHALL place in package stage_pipe_pkg: MAX_STAGES=8, COUNT_W=16, and the occupancy-width helper function.
REQ-031 SHALL instantiate one sub-module stage_pipe_slot per stage, holding a valid/data register with ready = !valid || ready_next.
REQ-032 SHALL check with elaboration-time assertions that STAGES is in 1..MAX_STAGES and DATA_W is in 1..64.

Verification (DATA_W=8, STAGES=2)
REQ-033 SHALL verify: reset, then 0x11 sent with out_ready=1 -> out_valid high 2 cycles later with out_data=0x11, occupancy 1 then 0.
REQ-034 SHALL verify: stream 0x00..0x0F back-to-back with out_ready=1 -> 16 outputs in order on 16 consecutive cycles, in_ready never low.
REQ-035 SHALL verify: out_ready=0 while sending 0xA1,0xA2,0xA3 -> first two accepted, in_ready low on the third with occupancy=2; release out_ready -> 0xA1,0xA2,0xA3 out in order.
REQ-036 SHALL verify: a full chain with flush pulsed 1 cycle while 0x55 is offered -> occupancy=0 and out_valid=0 next cycle, 0x55 never appears.
REQ-037 SHALL verify: rst_n dropped asynchronously mid-stream -> out_valid, occupancy and xfer_count are 0 immediately, and no stale beat appears after release.
REQ-038 SHALL verify: with STAGE_PIPE_CNT_EN defined, xfer_count preset near wrap by 65537 transfers -> reads 0x0001; without the macro, the bench compiles with no xfer_count port.
